// File: rtl/rifl_pkg.sv
// Shared types for the TX frame scheduler: frame/state encodings and counter sizing.
package rifl_pkg;

  typedef enum logic [1:0] {
    FT_INIT  = 2'd0,
    FT_IDLE  = 2'd1,
    FT_DATA  = 2'd2,
    FT_PAUSE = 2'd3
  } frame_type_t;

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_UP      = 2'd1,
    S_RETRANS = 2'd2
  } tx_ctrl_state_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector: registers the previous level and flags a 0->1 change
// in the same cycle the new level is presented.
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/tx_frame_ctrl.sv
// TX frame scheduler: chooses INIT/IDLE/DATA/PAUSE/replay frames each cycle.
// Retransmission support is built only when TX_FRAME_CTRL_RETRANS_EN is defined.
module tx_frame_ctrl
  import rifl_pkg::*;
#(
  parameter int INIT_FRAMES    = 64,
  parameter int RETRANS_DEPTH  = 32,
  parameter int PAUSE_INTERVAL = 16
) (
  input  logic       tx_frame_clk,
  input  logic       rst_n,
  input  logic       pause_req,
  input  logic       retrans_req,
  input  logic       rx_aligned,
  input  logic       rx_up,
  input  logic       rx_error,
  input  logic       local_pause,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [1:0] frame_type,
  output logic       frame_src_replay,
  output logic       retrans_start,
  output logic       tx_up
);

  localparam int ALIGN_W = cnt_w(INIT_FRAMES - 1);
  localparam int PTMR_W  = cnt_w(PAUSE_INTERVAL - 1);
  localparam logic [ALIGN_W-1:0] ALIGN_MAX   = ALIGN_W'(INIT_FRAMES - 1);
  localparam logic [PTMR_W-1:0]  PTMR_RELOAD = PTMR_W'(PAUSE_INTERVAL - 1);

  tx_ctrl_state_t       r_state;
  tx_ctrl_state_t       w_state_nxt;
  frame_type_t          r_frame_type;
  frame_type_t          w_ft_nxt;
  logic                 r_data_ready;
  logic                 w_ready_nxt;
  logic                 r_src_replay;
  logic                 w_src_nxt;
  logic                 r_retrans_start;
  logic                 w_rstart_nxt;
  logic                 r_tx_up;
  logic                 w_tx_up_nxt;
  logic [ALIGN_W-1:0]   r_align_cnt;
  logic [ALIGN_W-1:0]   w_align_nxt;
  logic [PTMR_W-1:0]    r_pause_tmr;
  logic [PTMR_W-1:0]    w_ptmr_nxt;
  logic [PTMR_W-1:0]    w_ptmr_run;
  logic                 w_link_ok;
  logic                 w_pause_fire;

`ifdef TX_FRAME_CTRL_RETRANS_EN
  localparam int REPLAY_W = cnt_w(RETRANS_DEPTH);
  localparam logic [REPLAY_W-1:0] REPLAY_LOAD = REPLAY_W'(RETRANS_DEPTH);

  logic [REPLAY_W-1:0]  r_replay_cnt;
  logic [REPLAY_W-1:0]  w_rcnt_nxt;
  logic                 w_retrans_rise;

  rise_edge_det u_retrans_edge (
    .clk    (tx_frame_clk),
    .rst_n  (rst_n),
    .i_sig  (retrans_req),
    .o_rise (w_retrans_rise)
  );

  always_ff @(posedge tx_frame_clk) begin
    if (!rst_n) begin
      r_replay_cnt <= '0;
    end else begin
      r_replay_cnt <= w_rcnt_nxt;
    end
  end
`else
  logic w_unused_retrans;
  assign w_unused_retrans = retrans_req ^ (RETRANS_DEPTH != 0);
`endif

  assign w_link_ok    = rx_up && !rx_error;
  assign w_pause_fire = local_pause && (r_pause_tmr == '0);
  // Timer counts down to zero and parks there; dropping local_pause rearms it.
  assign w_ptmr_run   = (local_pause && (r_pause_tmr != '0)) ? r_pause_tmr - 1'b1 : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_ft_nxt     = FT_INIT;
    w_ready_nxt  = 1'b0;
    w_src_nxt    = 1'b0;
    w_rstart_nxt = 1'b0;
    w_tx_up_nxt  = 1'b0;
    w_align_nxt  = '0;
    w_ptmr_nxt   = '0;
`ifdef TX_FRAME_CTRL_RETRANS_EN
    w_rcnt_nxt   = '0;
`endif
    case (r_state)
      S_INIT: begin
        if (rx_aligned) begin
          w_align_nxt = (r_align_cnt == ALIGN_MAX) ? r_align_cnt : r_align_cnt + 1'b1;
        end
        if (rx_aligned && rx_up && (r_align_cnt == ALIGN_MAX)) begin
          w_state_nxt = S_UP;
          w_align_nxt = '0;
        end
      end
      S_UP: begin
        // Link loss leaves every next-value at its cleared default.
        if (!w_link_ok) begin
          w_state_nxt = S_INIT;
        end else begin
          w_tx_up_nxt = 1'b1;
          w_ptmr_nxt  = w_ptmr_run;
`ifdef TX_FRAME_CTRL_RETRANS_EN
          if (w_retrans_rise) begin
            w_rstart_nxt = 1'b1;
            w_rcnt_nxt   = REPLAY_LOAD;
            w_state_nxt  = S_RETRANS;
            w_ft_nxt     = FT_IDLE;
          end else
`endif
          if (w_pause_fire) begin
            w_ft_nxt   = FT_PAUSE;
            w_ptmr_nxt = PTMR_RELOAD;
          end else if (pause_req) begin
            w_ft_nxt = FT_IDLE;
          end else if (data_valid) begin
            w_ft_nxt    = FT_DATA;
            w_ready_nxt = 1'b1;
          end else begin
            w_ft_nxt = FT_IDLE;
          end
        end
      end
`ifdef TX_FRAME_CTRL_RETRANS_EN
      S_RETRANS: begin
        if (!w_link_ok) begin
          w_state_nxt = S_INIT;
        end else begin
          w_tx_up_nxt = 1'b1;
          w_ptmr_nxt  = w_ptmr_run;
          w_rcnt_nxt  = r_replay_cnt;
          if (w_retrans_rise) begin
            w_rstart_nxt = 1'b1;
            w_rcnt_nxt   = REPLAY_LOAD;
            w_ft_nxt     = FT_IDLE;
          end else if (w_pause_fire) begin
            w_ft_nxt   = FT_PAUSE;
            w_ptmr_nxt = PTMR_RELOAD;
          end else if (pause_req) begin
            w_ft_nxt = FT_IDLE;
          end else begin
            w_ft_nxt   = FT_DATA;
            w_src_nxt  = 1'b1;
            w_rcnt_nxt = r_replay_cnt - 1'b1;
            if (r_replay_cnt == REPLAY_W'(1)) begin
              w_state_nxt = S_UP;
            end
          end
        end
      end
`endif
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  always_ff @(posedge tx_frame_clk) begin
    if (!rst_n) begin
      r_state         <= S_INIT;
      r_frame_type    <= FT_INIT;
      r_data_ready    <= 1'b0;
      r_src_replay    <= 1'b0;
      r_retrans_start <= 1'b0;
      r_tx_up         <= 1'b0;
      r_align_cnt     <= '0;
      r_pause_tmr     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_frame_type    <= w_ft_nxt;
      r_data_ready    <= w_ready_nxt;
      r_src_replay    <= w_src_nxt;
      r_retrans_start <= w_rstart_nxt;
      r_tx_up         <= w_tx_up_nxt;
      r_align_cnt     <= w_align_nxt;
      r_pause_tmr     <= w_ptmr_nxt;
    end
  end

  assign frame_type       = r_frame_type;
  assign data_ready       = r_data_ready;
  assign frame_src_replay = r_src_replay;
  assign retrans_start    = r_retrans_start;
  assign tx_up            = r_tx_up;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed bench for tx_frame_ctrl; replay scenarios run when TX_FRAME_CTRL_RETRANS_EN is defined.
module tb_tx_frame_ctrl;

  localparam int INIT_FRAMES    = 64;
  localparam int RETRANS_DEPTH  = 32;
  localparam int PAUSE_INTERVAL = 16;

  localparam logic [1:0] T_INIT  = 2'd0;
  localparam logic [1:0] T_IDLE  = 2'd1;
  localparam logic [1:0] T_DATA  = 2'd2;
  localparam logic [1:0] T_PAUSE = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pause_req, retrans_req, rx_aligned, rx_up, rx_error, local_pause, data_valid;
  logic       data_ready, frame_src_replay, retrans_start, tx_up;
  logic [1:0] frame_type;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tx_frame_ctrl #(
    .INIT_FRAMES    (INIT_FRAMES),
    .RETRANS_DEPTH  (RETRANS_DEPTH),
    .PAUSE_INTERVAL (PAUSE_INTERVAL)
  ) dut (
    .tx_frame_clk     (clk),
    .rst_n            (rst_n),
    .pause_req        (pause_req),
    .retrans_req      (retrans_req),
    .rx_aligned       (rx_aligned),
    .rx_up            (rx_up),
    .rx_error         (rx_error),
    .local_pause      (local_pause),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .frame_type       (frame_type),
    .frame_src_replay (frame_src_replay),
    .retrans_start    (retrans_start),
    .tx_up            (tx_up)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed as {frame_type, data_ready, frame_src_replay, retrans_start, tx_up}.
  task automatic expect_out(input string tag, input logic [1:0] ft, input logic rdy,
                            input logic src, input logic rs, input logic up);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {frame_type, data_ready, frame_src_replay, retrans_start, tx_up};
    exp = {ft, rdy, src, rs, up};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    pause_req = 1'b0; retrans_req = 1'b0; rx_aligned = 1'b0; rx_up = 1'b0;
    rx_error = 1'b0; local_pause = 1'b0; data_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values
    apply_reset();
    rst_n = 1'b0;
    step();
    expect_out("reset", T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Bring-up: INIT_FRAMES cycles of INIT, then data frames
    rx_aligned = 1'b1; rx_up = 1'b1; data_valid = 1'b1;
    for (int i = 0; i < INIT_FRAMES; i++) begin
      step();
      expect_out($sformatf("bringup_init[%0d]", i), T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step();
    expect_out("bringup_first_data", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);

    data_valid = 1'b0;
    step();
    expect_out("up_no_data_idle", T_IDLE, 1'b0, 1'b0, 1'b0, 1'b1);
    data_valid = 1'b1;

    // Remote pause holds the user frame
    pause_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out($sformatf("remote_pause[%0d]", i), T_IDLE, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    pause_req = 1'b0;
    step();
    expect_out("remote_pause_release", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);

    // Local pause: pause frames every PAUSE_INTERVAL cycles
    local_pause = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if ((k % PAUSE_INTERVAL) == 0)
        expect_out($sformatf("local_pause[%0d]", k), T_PAUSE, 1'b0, 1'b0, 1'b0, 1'b1);
      else
        expect_out($sformatf("local_pause[%0d]", k), T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    local_pause = 1'b0;
    step();
    expect_out("local_pause_release", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);

    // Link loss in UP, then re-initialisation from a cleared count
    rx_up = 1'b0;
    step();
    expect_out("linkloss_up", T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_up = 1'b1;
    for (int i = 0; i < INIT_FRAMES; i++) begin
      step();
      expect_out($sformatf("reinit[%0d]", i), T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step();
    expect_out("reinit_up", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);

`ifdef TX_FRAME_CTRL_RETRANS_EN
    // Plain retransmission
    retrans_req = 1'b1;
    step();
    expect_out("rt_start", T_IDLE, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < RETRANS_DEPTH; i++) begin
      step();
      expect_out($sformatf("rt_replay[%0d]", i), T_DATA, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    step();
    expect_out("rt_done", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);

    // Remote pause midway through a replay
    retrans_req = 1'b0;
    step();
    expect_out("rtp_gap", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);
    retrans_req = 1'b1;
    step();
    expect_out("rtp_start", T_IDLE, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out($sformatf("rtp_replay_a[%0d]", i), T_DATA, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    pause_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out($sformatf("rtp_hold[%0d]", i), T_IDLE, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    pause_req = 1'b0;
    for (int i = 0; i < RETRANS_DEPTH - 10; i++) begin
      step();
      expect_out($sformatf("rtp_replay_b[%0d]", i), T_DATA, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    step();
    expect_out("rtp_done", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);

    // Second rising edge mid-replay reloads the count
    retrans_req = 1'b0;
    step();
    expect_out("rtr_gap", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);
    retrans_req = 1'b1;
    step();
    expect_out("rtr_start", T_IDLE, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out($sformatf("rtr_replay_a[%0d]", i), T_DATA, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    retrans_req = 1'b0;
    step();
    expect_out("rtr_replay_fall", T_DATA, 1'b0, 1'b1, 1'b0, 1'b1);
    retrans_req = 1'b1;
    step();
    expect_out("rtr_restart", T_IDLE, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < RETRANS_DEPTH; i++) begin
      step();
      expect_out($sformatf("rtr_replay_b[%0d]", i), T_DATA, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    step();
    expect_out("rtr_done", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);

    // Local pause inside a replay does not consume a replay slot
    retrans_req = 1'b0;
    step();
    retrans_req = 1'b1;
    step();
    expect_out("rtl_start", T_IDLE, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("rtl_replay_a[%0d]", i), T_DATA, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    local_pause = 1'b1;
    step();
    expect_out("rtl_pause", T_PAUSE, 1'b0, 1'b0, 1'b0, 1'b1);
    local_pause = 1'b0;
    for (int i = 0; i < RETRANS_DEPTH - 3; i++) begin
      step();
      expect_out($sformatf("rtl_replay_b[%0d]", i), T_DATA, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    step();
    expect_out("rtl_done", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);

    // Error at replay frame 10
    retrans_req = 1'b0;
    step();
    retrans_req = 1'b1;
    step();
    expect_out("rte_start", T_IDLE, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out($sformatf("rte_replay[%0d]", i), T_DATA, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    rx_error = 1'b1;
    step();
    expect_out("rte_error", T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_error = 1'b0;
    retrans_req = 1'b0;
`else
    // Without retransmission support the request is ignored
    retrans_req = 1'b1;
    step();
    expect_out("nort_rise", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    expect_out("nort_hold", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);
    retrans_req = 1'b0;
    rx_error = 1'b1;
    step();
    expect_out("nort_error", T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_error = 1'b0;
`endif

    // Alignment count saturates while rx_up is low
    apply_reset();
    rx_aligned = 1'b1; rx_up = 1'b0; data_valid = 1'b1;
    for (int i = 0; i < INIT_FRAMES + 6; i++) begin
      step();
      expect_out($sformatf("sat_wait[%0d]", i), T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rx_up = 1'b1;
    step();
    expect_out("sat_transition", T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    expect_out("sat_up", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);

    // Alignment glitch at count 40 restarts the count
    apply_reset();
    rx_aligned = 1'b1; rx_up = 1'b1; data_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      expect_out($sformatf("glitch_pre[%0d]", i), T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rx_aligned = 1'b0;
    step();
    expect_out("glitch_drop", T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_aligned = 1'b1;
    for (int i = 0; i < INIT_FRAMES; i++) begin
      step();
      expect_out($sformatf("glitch_post[%0d]", i), T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step();
    expect_out("glitch_up", T_DATA, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-pause aborts on the next edge
    local_pause = 1'b1;
    step();
    expect_out("rst_pause_frame", T_PAUSE, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    step();
    expect_out("rst_mid_pause", T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    local_pause = 1'b0;
    step();
    expect_out("rst_after", T_INIT, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
